vector_norm_seq: RTL and testbench

Multi-cycle exact Euclidean magnitude unit: abs = floor(sqrt(x*x + y*y)). It is the sequential, exact counterpart of the combinational max + min/2 approximation (vector_abs), and serves as its golden hardware reference and as a drop-in where accuracy matters more than latency. It sits behind a valid/ready handshake on both sides, computes one square-root bit per clock, and processes one operand pair at a time.

---
 rtl/vector_norm_seq.sv | 112 +++++++++++
 tb/tb_vector_norm_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vector_norm_seq.sv
// Exact Euclidean magnitude floor(sqrt(x*x+y*y)), one root bit per clock; VECTOR_NORM_ROUND_EN gives round-to-nearest.
// Latency: result valid W+2 clocks after the accepting edge; one operand pair in flight at a time.
// Backpressure: in_ready_o only in IDLE; result and out_valid_o held in DONE until out_ready_i.
module vector_norm_seq #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W:0]   abs_o
);

  localparam int RW  = 2*W + 2;         // radicand: W+1 digit pairs
  localparam int RMW = W + 3;           // remainder never exceeds 2*root+2 bits
  localparam int CW  = $clog2(W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SQUARE = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [RW-1:0]  rad;
  logic [W:0]     root;
  logic [RMW-1:0] rem;
  logic [CW-1:0]  cnt;
  logic [W:0]     abs_q;

  logic [2*W-1:0] xx;
  logic [2*W-1:0] yy;
  logic [2*W:0]   sum;
  logic [RMW+1:0] rem_sh;
  logic [RMW+1:0] trial;
  logic [RMW+1:0] rem_nxt;
  logic           take;
  logic [W:0]     root_nxt;
  logic [W:0]     res_nxt;

  assign xx  = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
  assign yy  = {{W{1'b0}}, y_q} * {{W{1'b0}}, y_q};
  assign sum = {1'b0, xx} + {1'b0, yy};

  assign rem_sh   = {rem, rad[RW-1:RW-2]};
  assign trial    = {2'b00, root, 2'b01};
  assign take     = (rem_sh >= trial);
  assign rem_nxt  = take ? (rem_sh - trial) : rem_sh;
  assign root_nxt = {root[W-1:0], take};

`ifdef VECTOR_NORM_ROUND_EN
  // sum - r^2 > r  <=>  sqrt(sum) > r + 0.5
  assign res_nxt = ({{(RMW+1-W){1'b0}}, root_nxt} < rem_nxt) ? (root_nxt + (W+1)'(1)) : root_nxt;
`else
  assign res_nxt = root_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      rad   <= '0;
      root  <= '0;
      rem   <= '0;
      cnt   <= '0;
      abs_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            x_q   <= x_i;
            y_q   <= y_i;
            state <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          rad   <= {1'b0, sum};
          root  <= '0;
          rem   <= '0;
          cnt   <= CW'(W);
          state <= S_ITER;
        end
        S_ITER: begin
          rad  <= {rad[RW-3:0], 2'b00};
          rem  <= RMW'(rem_nxt);
          root <= root_nxt;
          if (cnt == '0) begin
            abs_q <= res_nxt;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == S_IDLE);
  assign out_valid_o = (state == S_DONE);
  assign abs_o       = abs_q;

endmodule

// File: tb/tb_vector_norm_seq.sv
// Directed and random checks of vector_norm_seq against an independent integer square-root model.
// Honours VECTOR_NORM_ROUND_EN for the expected rounding mode.
module tb_vector_norm_seq;
  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] x_i = '0;
  logic [W-1:0] y_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W:0]   abs_o;

  int n_checks = 0;
  int n_errors = 0;

  vector_norm_seq #(.W(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .abs_o       (abs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Binary search for the largest r with r*r <= s, then optional rounding.
  function automatic logic [W:0] ref_norm(input logic [W-1:0] x, input logic [W-1:0] y);
    longint s, lo, hi, mid;
    s  = longint'(x) * longint'(x) + longint'(y) * longint'(y);
    lo = 0;
    hi = 131071;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
`ifdef VECTOR_NORM_ROUND_EN
    if (s - lo * lo > lo) lo = lo + 1;
`endif
    return (W+1)'(lo);
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall,
                       input bit pulse, output logic [W:0] res, output int lat,
                       output bit busy_ok, output bit hold_ok);
    int wait_c;
    wait_c  = 0;
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!in_ready_o && wait_c < 100) begin
      @(posedge clk_i); #1;
      wait_c++;
    end
    check("in_ready_wait", {63'd0, in_ready_o}, 64'd1);
    x_i = x;
    y_i = y;
    in_valid_i  = 1'b1;
    out_ready_i = (stall == 0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    while (!out_valid_o && lat < 100) begin
      if (in_ready_o) busy_ok = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end
    check("out_valid_timeout", {63'd0, out_valid_o}, 64'd1);
    res = abs_o;
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 3) begin
        in_valid_i = 1'b1;
        x_i = 1;
        y_i = 0;
      end else begin
        in_valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
      if (!out_valid_o || abs_o !== res || in_ready_o) hold_ok = 1'b0;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] res;
    int lat;
    bit busy_ok, hold_ok;
    logic [W-1:0] rx, ry;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("reset_abs", 64'(abs_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("reset_in_ready", {63'd0, in_ready_o}, 64'd1);

    do_op(3, 4, 0, 1'b0, res, lat, busy_ok, hold_ok);
    check("3_4_abs", 64'(res), 64'd5);
    check("3_4_latency", 64'(lat), 64'd18);
    check("3_4_busy", {63'd0, busy_ok}, 64'd1);
    check("3_4_in_ready_after", {63'd0, in_ready_o}, 64'd1);
    check("3_4_out_valid_after", {63'd0, out_valid_o}, 64'd0);

    do_op(0, 0, 0, 1'b0, res, lat, busy_ok, hold_ok);
    check("0_0_abs", 64'(res), 64'd0);
    do_op(1, 1, 1, 1'b0, res, lat, busy_ok, hold_ok);
    check("1_1_abs", 64'(res), 64'd1);
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, res, lat, busy_ok, hold_ok);
    check("max_abs", 64'(res), 64'd92680);
    check("max_latency", 64'(lat), 64'd18);
    do_op(2, 3, 0, 1'b0, res, lat, busy_ok, hold_ok);
`ifdef VECTOR_NORM_ROUND_EN
    check("2_3_abs", 64'(res), 64'd4);
`else
    check("2_3_abs", 64'(res), 64'd3);
`endif
    do_op(5, 5, 2, 1'b0, res, lat, busy_ok, hold_ok);
    check("5_5_abs", 64'(res), 64'd7);

    do_op(6, 8, 10, 1'b1, res, lat, busy_ok, hold_ok);
    check("bp_abs", 64'(res), 64'd10);
    check("bp_hold", {63'd0, hold_ok}, 64'd1);
    check("bp_out_valid_after", {63'd0, out_valid_o}, 64'd0);
    check("bp_in_ready_after", {63'd0, in_ready_o}, 64'd1);
    do_op(1, 0, 0, 1'b0, res, lat, busy_ok, hold_ok);
    check("bp_next_abs", 64'(res), 64'd1);
    check("bp_next_abs_o", 64'(abs_o), 64'd1);

    x_i = 300;
    y_i = 400;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_mid_abs", 64'(abs_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rst_mid_in_ready", {63'd0, in_ready_o}, 64'd1);
    check("rst_mid_out_valid2", {63'd0, out_valid_o}, 64'd0);
    do_op(300, 400, 0, 1'b0, res, lat, busy_ok, hold_ok);
    check("rst_retry_abs", 64'(res), 64'd500);

    for (int i = 0; i < 200; i++) begin
      rx = W'($urandom_range(0, 65535));
      ry = W'($urandom_range(0, 65535));
      if (i == 0) begin rx = 16'hFFFF; ry = 0; end
      if (i == 1) begin rx = 0; ry = 16'hFFFE; end
      do_op(rx, ry, int'($urandom_range(0, 3)), 1'b0, res, lat, busy_ok, hold_ok);
      check("rand_abs", 64'(res), 64'(ref_norm(rx, ry)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
